// File: rtl/gyro_spi_pkg.sv
// Shared constants for the gyro SPI register interface: register map, bit positions
// of the command byte and the slave FSM encoding.
package gyro_spi_pkg;

  localparam logic [5:0] ADDR_WHO_AM_I  = 6'h0F;
  localparam logic [5:0] ADDR_CTRL_REG1 = 6'h20;
  localparam logic [5:0] ADDR_OUT_TEMP  = 6'h26;
  localparam logic [5:0] ADDR_OUT_X_L   = 6'h28;
  localparam logic [5:0] ADDR_OUT_X_H   = 6'h29;
  localparam logic [5:0] ADDR_OUT_Y_L   = 6'h2A;
  localparam logic [5:0] ADDR_OUT_Y_H   = 6'h2B;
  localparam logic [5:0] ADDR_OUT_Z_L   = 6'h2C;
  localparam logic [5:0] ADDR_OUT_Z_H   = 6'h2D;

  localparam logic [7:0] CTRL_REG1_RST  = 8'h07;

  localparam int unsigned RW_BIT = 7;
  localparam int unsigned MS_BIT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_gyro_slave_if.sv
// SPI pin bundle between a gyro master and spi_gyro_slave.
interface spi_gyro_slave_if;
  logic sclk;
  logic ss_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport slave  (input sclk, ss_n, mosi, output miso, miso_oe);
  modport master (output sclk, ss_n, mosi, input miso, miso_oe);
endinterface

// File: rtl/spi_edge_sync.sv
// Synchronizes sclk/ss_n/mosi into clk and produces one-cycle edge pulses.
module spi_edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic ss_n,
  input  logic mosi,
  output logic ss_n_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_fall,
  output logic ss_rise
);

  logic [2:0]      sync_q [STAGES];
  logic            sclk_s;
  logic            sclk_d;
  logic            ss_d;
  logic [STAGES:0] fill_q;
  logic            armed;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < STAGES; i++) sync_q[i] <= '1;
      sclk_d <= 1'b1;
      ss_d   <= 1'b1;
      fill_q <= '0;
      armed  <= 1'b0;
    end else begin
      sync_q[0] <= {sclk, ss_n, mosi};
      for (int unsigned i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      sclk_d <= sclk_s;
      ss_d   <= ss_n_s;
      fill_q <= {fill_q[STAGES-1:0], 1'b1};
      if (fill_q[STAGES] && ss_n_s) armed <= 1'b1;
    end
  end

  assign sclk_s = sync_q[STAGES-1][2];
  assign ss_n_s = sync_q[STAGES-1][1];
  assign mosi_s = sync_q[STAGES-1][0];

  // The chain resets to 1, so ss_n held low across reset would look like a fresh
  // falling edge; select is only honoured after ss_n has been seen high post-flush.
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = armed & ~ss_n_s & ss_d;
  assign ss_rise   = ss_n_s & ~ss_d;

endmodule

// File: rtl/spi_gyro_slave.sv
// SPI mode-3 gyro register slave. Optional block-data-update via GYRO_SLAVE_BDU_EN:
// samples arriving during a transaction are held until ss_n rises.
module spi_gyro_slave
  import gyro_spi_pkg::*;
#(
  parameter int unsigned SCLK_SYNC_STAGES = 2,
  parameter logic [7:0]  WHO_AM_I_VAL     = 8'hD3
) (
  input  logic                    clk,
  input  logic                    rst,
  spi_gyro_slave_if.slave         spi,
  input  logic                    sample_valid,
  input  logic [7:0]              temp_in,
  input  logic [15:0]             x_in,
  input  logic [15:0]             y_in,
  input  logic [15:0]             z_in,
  output logic [7:0]              ctrl_reg1,
  output logic                    wr_strobe,
  output logic [5:0]              wr_addr,
  output logic [7:0]              wr_data
);

  logic ss_n_s, mosi_s, sclk_rise, sclk_fall, ss_fall, ss_rise;

  spi_edge_sync #(.STAGES(SCLK_SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (spi.sclk),
    .ss_n      (spi.ss_n),
    .mosi      (spi.mosi),
    .ss_n_s    (ss_n_s),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise)
  );

  spi_state_t  state_q, state_d;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sh;
  logic [7:0]  tx_sh;
  logic [5:0]  addr;
  logic        rw, ms;
  logic        miso_q;
  logic [7:0]  rx_next;
  logic [5:0]  addr_next;
  logic [7:0]  temp_q;
  logic [15:0] x_q, y_q, z_q;

  assign rx_next   = {rx_sh, mosi_s};
  assign addr_next = ms ? addr + 6'd1 : addr;

  function automatic logic [7:0] reg_rd(input logic [5:0] a);
    case (a)
      ADDR_WHO_AM_I:  reg_rd = WHO_AM_I_VAL;
      ADDR_CTRL_REG1: reg_rd = ctrl_reg1;
      ADDR_OUT_TEMP:  reg_rd = temp_q;
      ADDR_OUT_X_L:   reg_rd = x_q[7:0];
      ADDR_OUT_X_H:   reg_rd = x_q[15:8];
      ADDR_OUT_Y_L:   reg_rd = y_q[7:0];
      ADDR_OUT_Y_H:   reg_rd = y_q[15:8];
      ADDR_OUT_Z_L:   reg_rd = z_q[7:0];
      ADDR_OUT_Z_H:   reg_rd = z_q[15:8];
      default:        reg_rd = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ss_rise) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (ss_fall) state_d = ADDR;
        ADDR:    if (sclk_rise && bit_cnt == 3'd7) state_d = DATA;
        DATA:    state_d = DATA;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      addr      <= '0;
      rw        <= 1'b0;
      ms        <= 1'b0;
      miso_q    <= 1'b1;
      ctrl_reg1 <= CTRL_REG1_RST;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (ss_rise) begin
        bit_cnt <= '0;
        miso_q  <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            miso_q <= 1'b1;
            if (ss_fall) bit_cnt <= '0;
          end
          ADDR: begin
            if (sclk_rise) begin
              rx_sh   <= rx_next[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw    <= rx_next[RW_BIT];
                ms    <= rx_next[MS_BIT];
                addr  <= rx_next[5:0];
                tx_sh <= rx_next[RW_BIT] ? reg_rd(rx_next[5:0]) : 8'h00;
              end
            end
          end
          DATA: begin
            if (sclk_fall) begin
              miso_q <= tx_sh[7];
              tx_sh  <= {tx_sh[6:0], 1'b0};
            end
            if (sclk_rise) begin
              rx_sh   <= rx_next[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr <= addr_next;
                if (rw) begin
                  tx_sh <= reg_rd(addr_next);
                end else if (addr == ADDR_CTRL_REG1) begin
                  ctrl_reg1 <= rx_next;
                  wr_strobe <= 1'b1;
                  wr_addr   <= addr;
                  wr_data   <= rx_next;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef GYRO_SLAVE_BDU_EN
  logic [7:0]  sh_temp;
  logic [15:0] sh_x, sh_y, sh_z;
  logic        sh_pend;

  // On the ss_n rise cycle ss_n_s is already high, so a coincident new sample
  // goes straight in and wins over the older shadow contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      temp_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      sh_temp <= '0;
      sh_x    <= '0;
      sh_y    <= '0;
      sh_z    <= '0;
      sh_pend <= 1'b0;
    end else begin
      if (ss_rise && sh_pend) begin
        temp_q  <= sh_temp;
        x_q     <= sh_x;
        y_q     <= sh_y;
        z_q     <= sh_z;
        sh_pend <= 1'b0;
      end
      if (sample_valid) begin
        if (!ss_n_s) begin
          sh_temp <= temp_in;
          sh_x    <= x_in;
          sh_y    <= y_in;
          sh_z    <= z_in;
          sh_pend <= 1'b1;
        end else begin
          temp_q <= temp_in;
          x_q    <= x_in;
          y_q    <= y_in;
          z_q    <= z_in;
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      temp_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
    end else if (sample_valid) begin
      temp_q <= temp_in;
      x_q    <= x_in;
      y_q    <= y_in;
      z_q    <= z_in;
    end
  end
`endif

  assign spi.miso    = miso_q;
  assign spi.miso_oe = (state_q != IDLE) && !ss_n_s;

endmodule

// File: tb/tb_spi_gyro_slave.sv
// Directed bench for spi_gyro_slave: a mode-3 SPI master driven from one initial block.
module tb_spi_gyro_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [7:0]  temp_in;
  logic [15:0] x_in, y_in, z_in;
  logic [7:0]  ctrl_reg1;
  logic        wr_strobe;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;

  spi_gyro_slave_if spi ();

  spi_gyro_slave #(.SCLK_SYNC_STAGES(2), .WHO_AM_I_VAL(8'hD3)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi          (spi),
    .sample_valid (sample_valid),
    .temp_in      (temp_in),
    .x_in         (x_in),
    .y_in         (y_in),
    .z_in         (z_in),
    .ctrl_reg1    (ctrl_reg1),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned wr_cnt = 0;
  logic [5:0]  last_wa = '0;
  logic [7:0]  last_wd = '0;
  logic [7:0]  tx_buf [8];
  logic [7:0]  rx_buf [8];
  logic [7:0]  exp_b  [6];
  logic        oe_mid, oe_end;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= wr_addr;
      last_wd <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_tx();
    for (int i = 0; i < 8; i++) begin
      tx_buf[i] = 8'h00;
      rx_buf[i] = 8'h00;
    end
  endtask

  // Mode 3 master: mosi changes on the falling sclk edge, miso sampled before rising.
  task automatic spi_xfer(input int nbits, input int pulse_byte, input int rst_byte);
    spi.ss_n = 1'b0;
    repeat (8) @(negedge clk);
    oe_mid = spi.miso_oe;
    for (int i = 0; i < nbits; i++) begin
      int byte_i = i / 8;
      int bit_i  = 7 - (i % 8);
      if (i % 8 == 0 && byte_i == pulse_byte) begin
        @(negedge clk) sample_valid = 1'b1;
        @(negedge clk) sample_valid = 1'b0;
      end
      if (i % 8 == 0 && byte_i == rst_byte) begin
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_miso",    16'(spi.miso),    16'h1);
        check("rst_mid_oe",      16'(spi.miso_oe), 16'h0);
        check("rst_mid_ctrl",    16'(ctrl_reg1),   16'h07);
        check("rst_mid_strobe",  16'(wr_strobe),   16'h0);
        check("rst_mid_wr_addr", 16'(wr_addr),     16'h0);
        check("rst_mid_wr_data", 16'(wr_data),     16'h0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
      end
      spi.sclk = 1'b0;
      spi.mosi = tx_buf[byte_i][bit_i];
      #50;
      rx_buf[byte_i][bit_i] = spi.miso;
      spi.sclk = 1'b1;
      #50;
    end
    #50;
    oe_end = spi.miso_oe;
    spi.ss_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    spi.sclk = 1'b1;
    spi.ss_n = 1'b1;
    spi.mosi = 1'b1;
    sample_valid = 1'b0;
    temp_in = '0; x_in = '0; y_in = '0; z_in = '0;
    clear_tx();
    repeat (3) @(negedge clk);
    check("reset_miso",    16'(spi.miso),    16'h1);
    check("reset_oe",      16'(spi.miso_oe), 16'h0);
    check("reset_ctrl",    16'(ctrl_reg1),   16'h07);
    check("reset_strobe",  16'(wr_strobe),   16'h0);
    check("reset_wr_addr", 16'(wr_addr),     16'h0);
    check("reset_wr_data", 16'(wr_data),     16'h0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // Write CTRL_REG1 = 0x0F
    clear_tx(); tx_buf[0] = 8'h20; tx_buf[1] = 8'h0F;
    spi_xfer(16, -1, -1);
    check("wr_count",   16'(wr_cnt),    16'd1);
    check("wr_addr",    16'(last_wa),   16'h20);
    check("wr_data",    16'(last_wd),   16'h0F);
    check("ctrl_after", 16'(ctrl_reg1), 16'h0F);

    // WHO_AM_I
    clear_tx(); tx_buf[0] = 8'h8F;
    spi_xfer(16, -1, -1);
    check("who_am_i", 16'(rx_buf[1]), 16'hD3);
    check("oe_active", 16'(oe_mid), 16'h1);

    // Load a sample and burst-read all axes
    @(negedge clk);
    temp_in = 8'h19; x_in = 16'h1234; y_in = 16'h5678; z_in = 16'hABCD;
    sample_valid = 1'b1;
    @(negedge clk) sample_valid = 1'b0;
    clear_tx(); tx_buf[0] = 8'hE8;
    spi_xfer(56, -1, -1);
    exp_b[0] = 8'h34; exp_b[1] = 8'h12; exp_b[2] = 8'h78;
    exp_b[3] = 8'h56; exp_b[4] = 8'hCD; exp_b[5] = 8'hAB;
    for (int k = 0; k < 6; k++) check($sformatf("axes_b%0d", k), 16'(rx_buf[k+1]), 16'(exp_b[k]));

    // Fixed-address read of OUT_TEMP
    clear_tx(); tx_buf[0] = 8'hA6;
    spi_xfer(24, -1, -1);
    check("temp_b0", 16'(rx_buf[1]), 16'h19);
    check("temp_b1", 16'(rx_buf[2]), 16'h19);

    // Auto-increment across temp, unmapped 0x27, X_L
    clear_tx(); tx_buf[0] = 8'hE6;
    spi_xfer(32, -1, -1);
    check("inc_temp",  16'(rx_buf[1]), 16'h19);
    check("inc_unmap", 16'(rx_buf[2]), 16'h00);
    check("inc_x_l",   16'(rx_buf[3]), 16'h34);

    // Unmapped read
    clear_tx(); tx_buf[0] = 8'h81;
    spi_xfer(16, -1, -1);
    check("unmapped_rd", 16'(rx_buf[1]), 16'h00);

    // Partial data byte must be dropped
    clear_tx(); tx_buf[0] = 8'h20; tx_buf[1] = 8'hA5;
    spi_xfer(12, -1, -1);
    check("partial_wr_count", 16'(wr_cnt),    16'd1);
    check("partial_ctrl",     16'(ctrl_reg1), 16'h0F);

    // Write to a read-only register
    clear_tx(); tx_buf[0] = 8'h0F; tx_buf[1] = 8'h55;
    spi_xfer(16, -1, -1);
    check("ro_wr_count", 16'(wr_cnt), 16'd1);

    // New sample arrives after the X_H byte has been loaded
    temp_in = 8'h44; x_in = 16'h1111; y_in = 16'h2222; z_in = 16'h3333;
    clear_tx(); tx_buf[0] = 8'hE8;
    spi_xfer(56, 2, -1);
`ifdef GYRO_SLAVE_BDU_EN
    exp_b[0] = 8'h34; exp_b[1] = 8'h12; exp_b[2] = 8'h78;
    exp_b[3] = 8'h56; exp_b[4] = 8'hCD; exp_b[5] = 8'hAB;
`else
    exp_b[0] = 8'h34; exp_b[1] = 8'h12; exp_b[2] = 8'h22;
    exp_b[3] = 8'h22; exp_b[4] = 8'h33; exp_b[5] = 8'h33;
`endif
    for (int k = 0; k < 6; k++) check($sformatf("midrd_b%0d", k), 16'(rx_buf[k+1]), 16'(exp_b[k]));
    clear_tx(); tx_buf[0] = 8'hE8;
    spi_xfer(56, -1, -1);
    exp_b[0] = 8'h11; exp_b[1] = 8'h11; exp_b[2] = 8'h22;
    exp_b[3] = 8'h22; exp_b[4] = 8'h33; exp_b[5] = 8'h33;
    for (int k = 0; k < 6; k++) check($sformatf("newrd_b%0d", k), 16'(rx_buf[k+1]), 16'(exp_b[k]));

    // Reset in the middle of a read; ss_n stays low across the release
    clear_tx(); tx_buf[0] = 8'hE8;
    spi_xfer(56, -1, 3);
    check("post_rst_oe_idle", 16'(oe_end), 16'h0);
    clear_tx(); tx_buf[0] = 8'hE8;
    spi_xfer(24, -1, -1);
    check("post_rst_x_l", 16'(rx_buf[1]), 16'h00);
    check("post_rst_x_h", 16'(rx_buf[2]), 16'h00);
    clear_tx(); tx_buf[0] = 8'h8F;
    spi_xfer(16, -1, -1);
    check("post_rst_who", 16'(rx_buf[1]), 16'hD3);
    check("post_rst_ctrl", 16'(ctrl_reg1), 16'h07);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_gyro_slave.md
SPI_GYRO_SLAVE -- requirements
Module: spi_gyro_slave

Interface
REQ-001 Parameter SCLK_SYNC_STAGES, default 2, number of synchronizer flops on sclk, ss_n and mosi.
REQ-002 Parameter WHO_AM_I_VAL, default 8'hD3, value returned at address 0x0F.
REQ-003 clk  in  1  single system clock; all logic is clocked on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low; takes effect on the rising edge of clk while rst==0.
REQ-005 sclk  in  1  SPI clock from the master, mode 3 (CPOL=1, CPHA=1), asynchronous to clk.
REQ-006 ss_n  in  1  slave select from the master, active-low.
REQ-007 mosi  in  1  serial data from the master, MSB first.
REQ-008 miso  out  1  serial data to the master, MSB first.
REQ-009 miso_oe  out  1  miso drive enable; 1 only while ss_n is synchronized low.
REQ-010 sample_valid  in  1  one-cycle strobe; on this cycle temp_in, x_in, y_in and z_in are valid.
REQ-011 temp_in  in  8  temperature sample.
REQ-012 x_in, y_in, z_in  in  16 each  axis samples, two's complement.
REQ-013 ctrl_reg1  out  8  current value of CTRL_REG1 (address 0x20).
REQ-014 wr_strobe  out  1  one-cycle pulse for each accepted register write.
REQ-015 wr_addr  out  6  address of the accepted write, valid while wr_strobe is high.
REQ-016 wr_data  out  8  data of the accepted write, valid while wr_strobe is high.

Function
REQ-017 sclk, ss_n and mosi SHALL be synchronized; edges SHALL be detected on the synchronized sclk.
REQ-018 Supported sclk period SHALL be ≥8 clk cycles, with high and low phases each ≥4 clk cycles.
REQ-019 FSM states SHALL be IDLE, ADDR and DATA.
REQ-020 IDLE -> ADDR on the synchronized ss_n falling edge; bit counter cleared.
REQ-021 mosi SHALL be sampled on each sclk rising edge.
REQ-022 After 8 bits in ADDR, the byte SHALL be decoded: bit7=RW (1=read), bit6=MS (1=auto-increment), bits[5:0]=start address; then ADDR -> DATA.
REQ-023 On a read, the addressed register SHALL be loaded into the TX shifter in the same clk cycle the 8th address bit is sampled.
REQ-024 miso SHALL change only on sclk falling edges; the data MSB appears on the first falling edge after the address byte.
REQ-025 On a write, each completed 8-bit DATA byte SHALL be committed in the clk cycle after the 8th rising edge, with one wr_strobe pulse.
REQ-026 Register map: 0x0F WHO_AM_I (RO); 0x20 CTRL_REG1 (RW, reset 8'h07); 0x26 OUT_TEMP (RO); 0x28..0x2D X_L, X_H, Y_L, Y_H, Z_L, Z_H (RO).
REQ-027 Reads of unmapped addresses SHALL return 8'h00.
REQ-028 Writes to RO or unmapped addresses SHALL be ignored, with no wr_strobe.
REQ-029 When MS=1, the address SHALL increment after each DATA byte, wrapping 0x3F -> 0x00.
REQ-030 When MS=0, the address SHALL stay fixed for all DATA bytes.
REQ-031 ss_n rising edge in any state SHALL force IDLE next cycle.
REQ-032 A partially received byte at ss_n rise SHALL be discarded, with no write and no strobe.
REQ-033 sample_valid SHALL copy the inputs into the output registers; simultaneous sample_valid and a read load SHALL return the pre-update value.
REQ-034 In IDLE, miso SHALL be 1 and miso_oe SHALL be 0.

Reset
REQ-035 While rst==0: FSM=IDLE, bit counter=0, ctrl_reg1=8'h07, all sample registers=0, wr_strobe=0, wr_addr=0, wr_data=0, miso=1, miso_oe=0, synchronizers filled with 1.
REQ-036 Reset asserted mid-transaction SHALL abort it; after release, the slave waits for a fresh ss_n falling edge.

Configuration
REQ-037 Macro GYRO_SLAVE_BDU_EN defined: sample_valid during a transaction (ss_n low) SHALL be held in a shadow and applied on the cycle after ss_n rises; a newer sample overwrites the shadow.
REQ-038 Macro GYRO_SLAVE_BDU_EN undefined: REQ-033 applies at all times, and multi-byte reads may mix samples.

Structure
REQ-039 Package gyro_spi_pkg SHALL hold: the register address constants (0x0F, 0x20, 0x26, 0x28-0x2D), CTRL_REG1 reset value, the RW/MS bit positions and the FSM state encoding, shared with the SPI master.
REQ-040 Sub-module spi_edge_sync SHALL implement the synchronizers plus sclk rise/fall and ss_n fall/rise pulse outputs.

Verification
REQ-041 Write 0x20 then 0x0F -> one wr_strobe with wr_addr=0x20, wr_data=0x0F; ctrl_reg1=0x0F.
REQ-042 Read 0x8F with one dummy byte -> miso returns 0xD3.
REQ-043 Sample x=0x1234, y=0x5678, z=0xABCD; read 0xE8 plus 6 bytes -> 34 12 78 56 CD AB.
REQ-044 Sample temp=0x19; read 0xA6 plus 2 dummy bytes (MS=0) -> 0x19, 0x19.
REQ-045 Write 0x20, then raise ss_n after 4 data bits -> no wr_strobe; ctrl_reg1 unchanged.
REQ-046 With GYRO_SLAVE_BDU_EN: new sample_valid mid-read -> all 6 axis bytes from the old sample, new values on the next read. Separately: rst low mid-read -> all outputs return to REQ-035 values.
